// File: rtl/vdc_vtiming_gen_if.sv
// Bundle of CRTC vertical registers, horizontal line events and the vertical
// timing outputs shared between the VDC vertical generator and its neighbours.
interface vdc_vtiming_gen_if #(
    parameter int ROW_BITS  = 8,
    parameter int LINE_BITS = 5,
    parameter int SL_BITS   = 10
);
    logic                 enable;
    logic [ROW_BITS-1:0]  reg_vt;
    logic [LINE_BITS-1:0] reg_va;
    logic [ROW_BITS-1:0]  reg_vd;
    logic [ROW_BITS-1:0]  reg_vp;
    logic [3:0]           reg_vw;
    logic [1:0]           reg_im;
    logic [LINE_BITS-1:0] reg_ctv;
    logic [LINE_BITS-1:0] reg_vss;
    logic                 lineEnd;
    logic                 displayStart;
    logic                 hSyncStart;
    logic [SL_BITS-1:0]   cmp_line;
    logic                 cmp_en;
    logic                 irq_ack;

    logic                 fetchFrame;
    logic                 fetchRow;
    logic                 fetchLine;
    logic                 field;
    logic [ROW_BITS-1:0]  row;
    logic [LINE_BITS-1:0] line;
    logic [SL_BITS-1:0]   scanline;
    logic                 vVisible;
    logic                 vsync;
    logic                 vblank;
    logic                 updateBlink;
    logic                 irq;

    modport slave (
        input  enable, reg_vt, reg_va, reg_vd, reg_vp, reg_vw, reg_im, reg_ctv, reg_vss,
               lineEnd, displayStart, hSyncStart, cmp_line, cmp_en, irq_ack,
        output fetchFrame, fetchRow, fetchLine, field, row, line, scanline,
               vVisible, vsync, vblank, updateBlink, irq
    );

    modport master (
        output enable, reg_vt, reg_va, reg_vd, reg_vp, reg_vw, reg_im, reg_ctv, reg_vss,
               lineEnd, displayStart, hSyncStart, cmp_line, cmp_en, irq_ack,
        input  fetchFrame, fetchRow, fetchLine, field, row, line, scanline,
               vVisible, vsync, vblank, updateBlink, irq
    );
endinterface

// File: rtl/vdc_vtiming_gen.sv
// Vertical timing generator: row/line/scanline counting, fetch strobes,
// vsync/vblank, interlace field and a sticky raster-compare interrupt.
module vdc_vtiming_gen #(
    parameter int ROW_BITS  = 8,
    parameter int LINE_BITS = 5,
    parameter int SL_BITS   = 10,
    parameter int VB_WIDTH  = 24
) (
    input  logic             clk,
    input  logic             reset,
    vdc_vtiming_gen_if.slave vif
);
    localparam logic [1:0] PH_ROWS  = 2'd0;
    localparam logic [1:0] PH_ADJ   = 2'd1;
    localparam logic [1:0] PH_EXTRA = 2'd2;

    localparam logic [ROW_BITS-1:0]  ROW_ONE = {{(ROW_BITS-1){1'b0}}, 1'b1};
    localparam logic [LINE_BITS-1:0] LN_ONE  = {{(LINE_BITS-1){1'b0}}, 1'b1};
    localparam logic [SL_BITS-1:0]   SL_ONE  = {{(SL_BITS-1){1'b0}}, 1'b1};
    localparam logic [SL_BITS-1:0]   VB_LOAD = SL_BITS'(VB_WIDTH);

    logic [1:0]           r_phase;
    logic [ROW_BITS-1:0]  r_row;
    logic [LINE_BITS-1:0] r_nsl;
    logic [LINE_BITS-1:0] r_line;
    logic [SL_BITS-1:0]   r_scanline;
    logic                 r_field;
    logic                 r_fetch_frame;
    logic                 r_fetch_row;
    logic                 r_fetch_line;
    logic                 r_update_blink;
    logic                 r_vvisible;
    logic [4:0]           r_vs_cnt;
    logic [SL_BITS-1:0]   r_vb_cnt;
    logic                 r_vsync;
    logic                 r_vblank;
    logic                 r_irq;

    logic                 w_le;
    logic                 w_extra_due;
    logic                 w_va_nz;
    logic                 w_row_end;
    logic                 w_frame_end;
    logic [1:0]           w_ph_nxt;
    logic [ROW_BITS-1:0]  w_row_nxt;
    logic [LINE_BITS-1:0] w_nsl_nxt;
    logic [LINE_BITS-1:0] w_line_nxt;
    logic [SL_BITS-1:0]   w_sl_nxt;
    logic                 w_hs;
    logic                 w_sync_start;
    logic [4:0]           w_vs_load;
    logic                 w_irq_set;
    logic                 w_unused_im1;

    assign w_le         = vif.enable && vif.lineEnd;
    assign w_hs         = vif.enable && vif.hSyncStart;
    assign w_extra_due  = vif.reg_im[0] && r_field;
    assign w_va_nz      = (vif.reg_va != {LINE_BITS{1'b0}});
    assign w_unused_im1 = vif.reg_im[1];

    // Row-end detection and frame sequencing through rows, adjust row and extra line
    always_comb begin
        w_row_end   = 1'b1;
        w_frame_end = 1'b0;
        w_ph_nxt    = r_phase;
        case (r_phase)
            PH_ROWS:  w_row_end = (r_nsl >= vif.reg_ctv);
            PH_ADJ:   w_row_end = !w_va_nz || (r_nsl >= (vif.reg_va - LN_ONE));
            PH_EXTRA: w_row_end = 1'b1;
            default:  w_row_end = 1'b1;
        endcase
        if (w_row_end) begin
            case (r_phase)
                PH_ROWS: begin
                    if (r_row >= vif.reg_vt) begin
                        if (w_va_nz) begin
                            w_ph_nxt = PH_ADJ;
                        end else if (w_extra_due) begin
                            w_ph_nxt = PH_EXTRA;
                        end else begin
                            w_frame_end = 1'b1;
                        end
                    end else begin
                        w_ph_nxt = PH_ROWS;
                    end
                end
                PH_ADJ: begin
                    if (w_extra_due) begin
                        w_ph_nxt = PH_EXTRA;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
                PH_EXTRA: w_frame_end = 1'b1;
                default:  w_frame_end = 1'b1;
            endcase
        end else begin
            w_ph_nxt = r_phase;
        end
    end

    // Next counter values applied on the following lineEnd
    always_comb begin
        w_row_nxt  = r_row;
        w_nsl_nxt  = r_nsl;
        w_sl_nxt   = r_scanline;
        w_line_nxt = r_line;
        if (w_frame_end) begin
            w_ph_nxt_unused_guard();
            w_row_nxt  = {ROW_BITS{1'b0}};
            w_nsl_nxt  = {LINE_BITS{1'b0}};
            w_sl_nxt   = {SL_BITS{1'b0}};
            w_line_nxt = vif.reg_vss;
        end else begin
            w_row_nxt  = w_row_end ? (r_row + ROW_ONE) : r_row;
            w_nsl_nxt  = w_row_end ? {LINE_BITS{1'b0}} : (r_nsl + LN_ONE);
            w_sl_nxt   = (r_scanline == {SL_BITS{1'b1}}) ? r_scanline : (r_scanline + SL_ONE);
            w_line_nxt = (r_line >= vif.reg_ctv) ? {LINE_BITS{1'b0}} : (r_line + LN_ONE);
        end
    end

    function automatic void w_ph_nxt_unused_guard();
    endfunction

    assign w_sync_start = w_hs && (r_phase == PH_ROWS) && (r_row <= vif.reg_vt) &&
                          (r_row == vif.reg_vp) && (r_nsl == {LINE_BITS{1'b0}});
    assign w_vs_load    = (vif.reg_vw == 4'd0) ? 5'd16 : {1'b0, vif.reg_vw};
    assign w_irq_set    = w_le && vif.cmp_en && (w_sl_nxt == vif.cmp_line) && !w_unused_im1 | 
                          (w_le && vif.cmp_en && (w_sl_nxt == vif.cmp_line) && w_unused_im1);

    // Frame counters, fetch strobes, field and blink pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase        <= PH_ROWS;
            r_row          <= {ROW_BITS{1'b0}};
            r_nsl          <= {LINE_BITS{1'b0}};
            r_line         <= {LINE_BITS{1'b0}};
            r_scanline     <= {SL_BITS{1'b0}};
            r_field        <= 1'b0;
            r_fetch_frame  <= 1'b0;
            r_fetch_row    <= 1'b0;
            r_fetch_line   <= 1'b0;
            r_update_blink <= 1'b0;
        end else begin
            r_update_blink <= 1'b0;
            if (w_le) begin
                r_phase       <= w_frame_end ? PH_ROWS : w_ph_nxt;
                r_row         <= w_row_nxt;
                r_nsl         <= w_nsl_nxt;
                r_scanline    <= w_sl_nxt;
                r_line        <= w_line_nxt;
                r_fetch_frame <= w_frame_end;
                r_fetch_row   <= (w_nsl_nxt == {LINE_BITS{1'b0}}) && (w_row_nxt < vif.reg_vd);
                r_fetch_line  <= (w_row_nxt < vif.reg_vd);
                if (w_frame_end) begin
                    r_update_blink <= 1'b1;
                    r_field        <= vif.reg_im[0] ? ~r_field : 1'b0;
                end
            end
        end
    end

    // Vertical display window, sampled at the start of the active area
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vvisible <= 1'b0;
        end else if (vif.enable && vif.displayStart) begin
            r_vvisible <= (r_row < vif.reg_vd);
        end
    end

    // Vsync/vblank down-counters clocked by hsync starts; a start event reloads both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_cnt <= 5'd0;
            r_vb_cnt <= {SL_BITS{1'b0}};
            r_vsync  <= 1'b0;
            r_vblank <= 1'b0;
        end else if (w_sync_start) begin
            r_vs_cnt <= w_vs_load;
            r_vb_cnt <= VB_LOAD;
            r_vsync  <= 1'b1;
            r_vblank <= (VB_LOAD != {SL_BITS{1'b0}});
        end else if (w_hs) begin
            r_vs_cnt <= (r_vs_cnt != 5'd0) ? (r_vs_cnt - 5'd1) : 5'd0;
            r_vb_cnt <= (r_vb_cnt != {SL_BITS{1'b0}}) ? (r_vb_cnt - SL_ONE) : {SL_BITS{1'b0}};
            r_vsync  <= (r_vs_cnt > 5'd1);
            r_vblank <= (r_vb_cnt > SL_ONE);
        end
    end

    // Sticky raster interrupt; a new match beats a simultaneous acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (vif.enable && vif.irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign vif.fetchFrame  = r_fetch_frame;
    assign vif.fetchRow    = r_fetch_row;
    assign vif.fetchLine   = r_fetch_line;
    assign vif.field       = r_field;
    assign vif.row         = r_row;
    assign vif.line        = r_line;
    assign vif.scanline    = r_scanline;
    assign vif.vVisible    = r_vvisible;
    assign vif.vsync       = r_vsync;
    assign vif.vblank      = r_vblank;
    assign vif.updateBlink = r_update_blink;
    assign vif.irq         = r_irq;
endmodule

// File: tb/tb_vdc_vtiming_gen.sv
// Scoreboard bench for vdc_vtiming_gen: directed stimulus pushes hand-derived
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_vdc_vtiming_gen;
    localparam int ROW_BITS  = 8;
    localparam int LINE_BITS = 5;
    localparam int SL_BITS   = 10;
    localparam int VB_WIDTH  = 5;

    localparam int S_FF = 0, S_FR = 1, S_FL = 2, S_FIELD = 3, S_ROW = 4, S_LINE = 5;
    localparam int S_SL = 6, S_VIS = 7, S_VS = 8, S_VB = 9, S_BLINK = 10, S_IRQ = 11;

    typedef struct {
        int    sel;
        int    val;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   n_tests;
    int   n_fail;

    vdc_vtiming_gen_if #(.ROW_BITS(ROW_BITS), .LINE_BITS(LINE_BITS), .SL_BITS(SL_BITS)) vif ();

    vdc_vtiming_gen #(
        .ROW_BITS(ROW_BITS), .LINE_BITS(LINE_BITS), .SL_BITS(SL_BITS), .VB_WIDTH(VB_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .vif  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_out(input int sel);
        case (sel)
            S_FF:    return int'(vif.fetchFrame);
            S_FR:    return int'(vif.fetchRow);
            S_FL:    return int'(vif.fetchLine);
            S_FIELD: return int'(vif.field);
            S_ROW:   return int'(vif.row);
            S_LINE:  return int'(vif.line);
            S_SL:    return int'(vif.scanline);
            S_VIS:   return int'(vif.vVisible);
            S_VS:    return int'(vif.vsync);
            S_VB:    return int'(vif.vblank);
            S_BLINK: return int'(vif.updateBlink);
            S_IRQ:   return int'(vif.irq);
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every queued expectation at the falling edge
    initial begin
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                int   act;
                e   = q.pop_front();
                act = get_out(e.sel);
                n_tests++;
                if (act != e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.val, $time);
                end
            end
        end
    end

    task automatic chk(input int sel, input int val, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic le(input bit ack);
        @(posedge clk); #1;
        vif.lineEnd = 1'b1;
        vif.irq_ack = ack;
        @(posedge clk); #1;
        vif.lineEnd = 1'b0;
        vif.irq_ack = 1'b0;
    endtask

    task automatic hs();
        @(posedge clk); #1 vif.hSyncStart = 1'b1;
        @(posedge clk); #1 vif.hSyncStart = 1'b0;
    endtask

    task automatic ds();
        @(posedge clk); #1 vif.displayStart = 1'b1;
        @(posedge clk); #1 vif.displayStart = 1'b0;
    endtask

    task automatic ack();
        @(posedge clk); #1 vif.irq_ack = 1'b1;
        @(posedge clk); #1 vif.irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int s;
        int f;
        int fe;
        int ex;
        rst              = 1'b1;
        vif.enable       = 1'b1;
        vif.reg_vt       = 8'd3;
        vif.reg_va       = 5'd0;
        vif.reg_vd       = 8'd2;
        vif.reg_vp       = 8'd200;
        vif.reg_vw       = 4'd0;
        vif.reg_im       = 2'b00;
        vif.reg_ctv      = 5'd1;
        vif.reg_vss      = 5'd0;
        vif.lineEnd      = 1'b0;
        vif.displayStart = 1'b0;
        vif.hSyncStart   = 1'b0;
        vif.cmp_line     = 10'd0;
        vif.cmp_en       = 1'b0;
        vif.irq_ack      = 1'b0;

        #2;
        for (int i = 0; i < 12; i++) chk(i, 0, "reset_out");
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // 8-line frames, two displayed rows
        for (int k = 1; k <= 16; k++) begin
            le(1'b0);
            s = k % 8;
            chk(S_SL, s, "t1_scanline");
            chk(S_ROW, s / 2, "t1_row");
            chk(S_LINE, s % 2, "t1_line");
            chk(S_FF, int'(s == 0), "t1_fetchFrame");
            chk(S_FR, int'(s == 0 || s == 2), "t1_fetchRow");
            chk(S_FL, int'(s < 4), "t1_fetchLine");
            chk(S_FIELD, 0, "t1_field");
            chk(S_BLINK, int'(s == 0), "t1_blink");
            if (s == 2) begin ds(); chk(S_VIS, 1, "t1_vis_on"); end
            if (s == 4) begin ds(); chk(S_VIS, 0, "t1_vis_off"); end
        end
        vif.enable = 1'b0;
        le(1'b0);
        chk(S_SL, 0, "t1_enable_hold");
        vif.enable = 1'b1;

        // Adjust row plus interlace extra line: 11/12 line frames
        vif.reg_va = 5'd3;
        vif.reg_im = 2'b01;
        do_reset();
        s = 0;
        f = 0;
        for (int k = 1; k <= 46; k++) begin
            le(1'b0);
            if (s == ((f != 0) ? 11 : 10)) begin
                s = 0; f = 1 - f; fe = 1;
            end else begin
                s = s + 1; fe = 0;
            end
            chk(S_SL, s, "t2_scanline");
            chk(S_FIELD, f, "t2_field");
            chk(S_BLINK, fe, "t2_blink");
            chk(S_FF, fe, "t2_fetchFrame");
            chk(S_ROW, (s < 8) ? s / 2 : ((s < 11) ? 4 : 5), "t2_row");
            chk(S_LINE, s % 2, "t2_line");
        end

        // Vsync/vblank from row 2 with 32-line frames
        vif.reg_va = 5'd0;
        vif.reg_im = 2'b00;
        vif.reg_vt = 8'd15;
        vif.reg_vp = 8'd2;
        vif.reg_vw = 4'd0;
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            hs();
            chk(S_VS, int'(k >= 4 && k <= 19), "t3_vsync");
            chk(S_VB, int'(k >= 4 && k <= 8), "t3_vblank");
            le(1'b0);
        end
        vif.reg_vp = 8'd200;

        // Smooth scroll start line
        vif.reg_vt  = 8'd3;
        vif.reg_ctv = 5'd3;
        vif.reg_vss = 5'd1;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            le(1'b0);
            ex = (k < 16) ? (k % 4) : ((1 + k - 16) % 4);
            chk(S_LINE, ex, "t4_line");
        end
        vif.reg_ctv = 5'd1;
        vif.reg_vss = 5'd0;

        // Raster interrupt
        vif.cmp_line = 10'd5;
        vif.cmp_en   = 1'b1;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            le(1'b0);
            chk(S_IRQ, int'(k >= 5), "t5_irq_set");
        end
        ack();
        chk(S_IRQ, 0, "t5_irq_ack");
        for (int k = 8; k <= 13; k++) begin
            le(k == 13);
            chk(S_IRQ, int'(k == 13), "t5_irq_set_vs_ack");
        end
        vif.cmp_en = 1'b0;
        le(1'b0);
        chk(S_IRQ, 1, "t5_irq_pending_kept");
        ack();
        chk(S_IRQ, 0, "t5_irq_ack2");
        for (int k = 0; k < 8; k++) begin
            le(1'b0);
            chk(S_IRQ, 0, "t5_irq_disabled");
        end

        // Mid-frame asynchronous reset
        vif.reg_vd = 8'd4;
        do_reset();
        for (int k = 0; k < 5; k++) le(1'b0);
        chk(S_SL, 5, "t6_pre_scanline");
        chk(S_ROW, 2, "t6_pre_row");
        chk(S_FL, 1, "t6_pre_fetchLine");
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        chk(S_SL, 0, "t6_rst_scanline");
        chk(S_ROW, 0, "t6_rst_row");
        chk(S_FL, 0, "t6_rst_fetchLine");
        @(posedge clk); #1 rst = 1'b0;
        le(1'b0);
        chk(S_SL, 1, "t6_restart_scanline");
        chk(S_ROW, 0, "t6_restart_row");

        // Shrinking the vertical total mid-frame wraps at the next row end
        vif.reg_vd = 8'd2;
        vif.reg_vt = 8'd10;
        do_reset();
        for (int k = 0; k < 10; k++) le(1'b0);
        chk(S_ROW, 5, "t7_row5");
        vif.reg_vt = 8'd1;
        le(1'b0);
        chk(S_ROW, 5, "t7_row5_nsl1");
        chk(S_SL, 11, "t7_scanline11");
        le(1'b0);
        chk(S_SL, 0, "t7_wrap_scanline");
        chk(S_ROW, 0, "t7_wrap_row");
        chk(S_FF, 1, "t7_wrap_fetchFrame");

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
